// File: rtl/sequence_flasher_if.sv
// rtl/sequence_flasher_if.sv - round control, sequence readback and display signals of the sequence flasher
interface sequence_flasher_if;
  logic       start;
  logic       abort;
  logic [1:0] levelNumber;
  logic [1:0] speedNumber;
  logic [2:0] rdIndex;
  logic [3:0] rdDigit;
  logic [2:0] seqLength;
  logic [3:0] numToFlash;
  logic       noNumToFlash;
  logic       busy;
  logic       done;

  modport slave (
    input  start, abort, levelNumber, speedNumber, rdIndex,
    output rdDigit, seqLength, numToFlash, noNumToFlash, busy, done
  );

  modport master (
    output start, abort, levelNumber, speedNumber, rdIndex,
    input  rdDigit, seqLength, numToFlash, noNumToFlash, busy, done
  );
endinterface

// File: rtl/sequence_flasher.sv
// rtl/sequence_flasher.sv - generates a random BCD digit sequence per round and plays it out
// one digit at a time (show / blank) for the display controller.
module sequence_flasher #(
  parameter int unsigned TICKS_PER_UNIT = 25000000,
  parameter logic [7:0]  SEED           = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  sequence_flasher_if.slave bus
);

  localparam int unsigned CW = (4 * TICKS_PER_UNIT > 1) ? $clog2(4 * TICKS_PER_UNIT) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(TICKS_PER_UNIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [7:0]    lfsr_q;
  logic [7:0]    lfsr_d;
  logic [3:0]    seq_q [7];
  logic [2:0]    idx_q;
  logic [2:0]    len_q;
  logic [2:0]    on_q;
  logic [CW-1:0] tick_q;
  logic [CW-1:0] show_last;
  logic [3:0]    num_q;
  logic [3:0]    new_digit;
  logic [3:0]    rd_digit;
  logic          blank_q;
  logic          busy_q;
  logic          done_q;

  // Taps x^8+x^6+x^5+x^4+1: maximal length, so a nonzero seed never reaches zero.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    new_digit = lfsr_q[3:0];
    if (lfsr_q[3:0] > 4'd9) begin
      new_digit = lfsr_q[3:0] - 4'd6;
    end
  end

  assign show_last = CW'({29'd0, on_q} * TICKS_PER_UNIT - 32'd1);

  function automatic logic [3:0] slot(input logic [2:0] a);
    logic [3:0] v;
    v = 4'd0;
    for (int i = 0; i < 7; i++) begin
      if (a == 3'(i)) begin
        v = seq_q[i];
      end
    end
    return v;
  endfunction

  always_comb begin
    rd_digit = 4'd0;
    if (bus.rdIndex < len_q) begin
      rd_digit = slot(bus.rdIndex);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      idx_q   <= 3'd0;
      len_q   <= 3'd0;
      on_q    <= 3'd0;
      tick_q  <= '0;
      num_q   <= 4'd0;
      blank_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        seq_q[i] <= 4'd0;
      end
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      // Abort leaves the stored sequence and the held digit untouched.
      if (bus.abort) begin
        state_q <= S_IDLE;
        blank_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              state_q <= S_LOAD;
              len_q   <= {1'b0, bus.levelNumber} + 3'd4;
              on_q    <= 3'd4 - {1'b0, bus.speedNumber};
              idx_q   <= 3'd0;
              busy_q  <= 1'b1;
            end
          end
          S_LOAD: begin
            for (int i = 0; i < 7; i++) begin
              if (idx_q == 3'(i)) begin
                seq_q[i] <= new_digit;
              end
            end
            if (idx_q == len_q - 3'd1) begin
              // Slot 0 was written cycles ago, so it can be shown right away.
              state_q <= S_SHOW;
              idx_q   <= 3'd0;
              tick_q  <= '0;
              num_q   <= slot(3'd0);
              blank_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
          S_SHOW: begin
            if (tick_q == show_last) begin
              state_q <= S_GAP;
              tick_q  <= '0;
              blank_q <= 1'b1;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          S_GAP: begin
            if (tick_q == GAP_LAST) begin
              tick_q <= '0;
              if (idx_q == len_q - 3'd1) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_SHOW;
                idx_q   <= idx_q + 3'd1;
                num_q   <= slot(idx_q + 3'd1);
                blank_q <= 1'b0;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rdDigit      = rd_digit;
  assign bus.seqLength    = len_q;
  assign bus.numToFlash   = num_q;
  assign bus.noNumToFlash = blank_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_sequence_flasher.sv
// tb/tb_sequence_flasher.sv - randomized self-checking bench for sequence_flasher against a
// round-level playback model.
module tb_sequence_flasher;
  localparam int         T    = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk;
  logic rst;
  sequence_flasher_if sif ();

  sequence_flasher #(
    .TICKS_PER_UNIT(T),
    .SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  int         n_checks;
  int         n_fail;
  logic [7:0] m_lfsr;
  logic [3:0] prev_num;
  logic [3:0] last_dig [7];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic fb;
    fb = ^(v & 8'b1011_1000);
    return {v[6:0], fb};
  endfunction

  function automatic logic [3:0] to_digit(input logic [7:0] v);
    int n;
    n = int'(v[3:0]);
    return (n <= 9) ? 4'(n) : 4'(n - 6);
  endfunction

  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check_reset_values(input string tag);
    logic [10:0] obs;
    logic [10:0] exp_v;
    obs   = {sif.busy, sif.done, sif.noNumToFlash, sif.numToFlash, sif.seqLength};
    exp_v = {1'b0, 1'b0, 1'b1, 4'd0, 3'd0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s outputs {busy,done,blank,num,len}: got %b expected %b", tag, obs, exp_v);
    end
    for (int i = 0; i < 8; i++) begin
      sif.rdIndex = 3'(i);
      #1;
      n_checks++;
      if (sif.rdDigit !== 4'd0) begin
        n_fail++;
        $display("FAIL %s rdDigit[%0d]: got %0d expected 0", tag, i, sif.rdDigit);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.levelNumber = 2'd0;
    sif.speedNumber = 2'd0;
    sif.rdIndex = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    prev_num = 4'd0;
  endtask

  // Starts a round from IDLE and checks every cycle until one cycle after done.
  task automatic run_round(input logic [1:0] lvl, input logic [1:0] spd, input bit disturb,
                           input int abort_at, input string tag);
    int          len, on, per, total, r, di, w;
    logic [7:0]  v;
    logic [3:0]  dig [7];
    logic [6:0]  obs, exp_v;
    logic        e_busy, e_done, e_blank;
    logic [3:0]  e_num;
    bit          aborted;
    len   = int'(lvl) + 4;
    on    = 4 - int'(spd);
    per   = (on + 1) * T;
    total = len + len * per;
    aborted = 1'b0;
    e_num = prev_num;
    sif.levelNumber = lvl;
    sif.speedNumber = spd;
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    v = m_lfsr;
    for (int k = 0; k < 7; k++) begin
      dig[k] = to_digit(v);
      v = lfsr_step(v);
    end
    for (int t = 0; t <= total + 1; t++) begin
      if (abort_at >= 0 && t == abort_at + 1) begin
        e_busy = 1'b0; e_done = 1'b0; e_blank = 1'b1;
        aborted = 1'b1;
      end else if (t < len) begin
        e_busy = 1'b1; e_done = 1'b0; e_blank = 1'b1; e_num = prev_num;
      end else if (t < total) begin
        r = t - len; di = r / per; w = r % per;
        e_busy = 1'b1; e_done = 1'b0; e_blank = (w >= on * T); e_num = dig[di];
      end else begin
        e_busy = 1'b0; e_done = (t == total); e_blank = 1'b1; e_num = dig[len-1];
      end
      obs   = {sif.busy, sif.done, sif.noNumToFlash, sif.numToFlash};
      exp_v = {e_busy, e_done, e_blank, e_num};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d {busy,done,blank,num}: got %b expected %b", tag, t, obs, exp_v);
      end
      if (aborted) break;
      if (disturb) begin
        sif.start = (t == len + 1) || (t == len + on * T + 1) || (t == len + per + 2);
        if (t == len + 3) sif.levelNumber = ~lvl;
      end
      if (t == abort_at) sif.abort = 1'b1;
      @(posedge clk);
      #1;
      sif.start = 1'b0;
      sif.abort = 1'b0;
    end
    if (aborted) begin
      repeat (4) begin
        @(posedge clk);
        #1;
        n_checks++;
        if ({sif.busy, sif.done, sif.noNumToFlash} !== 3'b001) begin
          n_fail++;
          $display("FAIL %s post-abort {busy,done,blank}: got %b expected 001", tag,
                   {sif.busy, sif.done, sif.noNumToFlash});
        end
      end
    end
    n_checks++;
    if (sif.seqLength !== 3'(len)) begin
      n_fail++;
      $display("FAIL %s seqLength: got %0d expected %0d", tag, sif.seqLength, len);
    end
    for (int i = 0; i < 8; i++) begin
      sif.rdIndex = 3'(i);
      #1;
      n_checks++;
      if (i < len) begin
        if (sif.rdDigit !== dig[i] || sif.rdDigit > 4'd9) begin
          n_fail++;
          $display("FAIL %s rdDigit[%0d]: got %0d expected %0d", tag, i, sif.rdDigit, dig[i]);
        end
      end else if (sif.rdDigit !== 4'd0) begin
        n_fail++;
        $display("FAIL %s rdDigit[%0d] beyond length: got %0d expected 0", tag, i, sif.rdDigit);
      end
    end
    for (int i = 0; i < 7; i++) last_dig[i] = dig[i];
    prev_num = e_num;
  endtask

  task automatic test_basic_rounds;
    run_round(2'd0, 2'd3, 1'b0, -1, "lvl0_spd3");
    run_round(2'd3, 2'd0, 1'b0, -1, "lvl3_spd0");
  endtask

  task automatic test_random_rounds;
    for (int n = 0; n < 4; n++) begin
      run_round(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, -1, "random");
    end
  endtask

  task automatic test_ignored_inputs;
    run_round(2'd1, 2'd2, 1'b1, -1, "disturb");
  endtask

  task automatic test_abort;
    logic [1:0] lvl;
    lvl = 2'($urandom_range(0, 3));
    run_round(lvl, 2'd3, 1'b0, int'(lvl) + 4 + 2 * 2 * T + 1, "abort");
    run_round(2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)), 1'b0, -1, "after_abort");
    sif.start = 1'b1;
    sif.abort = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    repeat (2) begin
      n_checks++;
      if (sif.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_vs_start busy: got %b expected 0", sif.busy);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_gap;
    logic [3:0] first [7];
    int         len;
    len = int'(sif.levelNumber) + 4;
    sif.speedNumber = 2'd3;
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    repeat (len + T + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("reset_mid_gap");
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_num = 4'd0;
    repeat (5) @(posedge clk);
    #1;
    run_round(2'd2, 2'd3, 1'b0, -1, "determinism_a");
    for (int i = 0; i < 7; i++) first[i] = last_dig[i];
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    prev_num = 4'd0;
    repeat (5) @(posedge clk);
    #1;
    run_round(2'd2, 2'd3, 1'b0, -1, "determinism_b");
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (last_dig[i] !== first[i]) begin
        n_fail++;
        $display("FAIL determinism digit %0d: got %0d expected %0d", i, last_dig[i], first[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_rounds();
    test_random_rounds();
    test_ignored_inputs();
    test_abort();
    test_reset_mid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
